// File: rtl/shift_add_mult.sv
// Sequential radix-2 shift-add multiplier: full 2*WIDTH-bit unsigned product of a and b,
// one partial-product iteration per clock, start/busy/done handshake.
module shift_add_mult #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] p;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;

  // Partial sum of the high half, with the multiplicand added when the current
  // multiplier bit (p[0]) is set; kept WIDTH+1 bits so the carry is not lost.
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]};
    if (p[0]) begin
      sum = sum + {1'b0, a_reg};
    end
  end

  // The carry bit above the product is always zero after a shift, so it is not
  // stored; the shifted-in sum carry lands directly in the top of the high half.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_reg <= '0;
      p     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= a;
            p     <= {{WIDTH{1'b0}}, b};
            cnt   <= CNT_W'(WIDTH);
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          p   <= {sum, p[WIDTH-1:1]};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign product = p;

endmodule
